uart_rx: RTL and testbench

Serial receiver that sits directly downstream of `uart_tx`. It recovers 8N1-style frames from the `tx_wire` line and presents each received byte as a parallel word with a one-cycle `valid` strobe. The baud timing comes from a system-clock divider, and each bit is sampled once at its mid-point. It pairs with `uart_tx` for loopback and host-link use.

---
 rtl/uart_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Purpose : 8N1-style serial receiver; recovers frames from an idle-high line, one mid-bit sample per bit.
// Latency : valid/frame_error rise one cycle after the stop-bit sample (~2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT cycles after the start edge).
// Backpres: none; valid is a one-cycle strobe, rx_output holds the last good word until the next good frame.
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   enable      - receiver enable; low forces IDLE and clears the baud counter
//   rx_wire     - asynchronous serial input, idle high
//   rx_output   - last correctly framed data word
//   valid       - one-cycle pulse when rx_output is updated
//   frame_error - one-cycle pulse when the stop bit is sampled low
//   busy        - high whenever the receiver is not IDLE

module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int BAUD      = 9600,
    parameter int SYS_CLK   = 12000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rx_wire,
    output logic [DATA_BITS-1:0] rx_output,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Two-flop synchronizer; both flops reset high so a reset does not look like a start edge.
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  ferr_q, ferr_d;

    assign rx_s = sync2_q;

    // The synchronizer is independent of enable so the line history is
    // already settled when the receiver is switched on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_wire;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (!enable) begin
            // Disable aborts any frame silently; rx_output is retained.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_START;
                    end
                end

                S_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (cnt_q == CNT_HALF_LAST) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            idx_d   = '0;
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    // The counter is now phase-aligned to mid-bit, so every
                    // full bit period lands on the middle of the next bit.
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            out_d   = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_BREAK: begin
                    // Hold here until the line returns high so a stuck-low
                    // line is not decoded as a stream of frames.
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rx_output   = out_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    // Scaled-down line rate keeps frames short: 20 clocks per bit.
    localparam int  DATA_BITS = 8;
    localparam int  BAUD      = 1_000_000;
    localparam int  SYS_CLK   = 20_000_000;
    localparam int  CPB       = SYS_CLK / BAUD;
    localparam real CLK_NS    = 50.0;
    localparam real BIT_NS    = 1.0e9 / BAUD;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 rx_wire;
    logic [DATA_BITS-1:0] rx_output;
    logic                 valid;
    logic                 frame_error;
    logic                 busy;

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .BAUD      (BAUD),
        .SYS_CLK   (SYS_CLK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rx_wire     (rx_wire),
        .rx_output   (rx_output),
        .valid       (valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2.0) clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Scoreboard of expected receiver events, in frame order.
    typedef struct {
        bit         is_fe;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         ev_count   = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] model_out  = 8'h00;

    always @(negedge clk) begin
        if (valid || frame_error) begin
            ev_count++;
            check("pulse_exclusive", {31'b0, valid && frame_error}, 32'd0);
            check("pulse_one_cycle", {31'b0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: valid=%0b frame_error=%0b rx_output=%0h at %0t",
                         valid, frame_error, rx_output, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind_fe", {31'b0, frame_error}, {31'b0, e.is_fe});
                check("event_rx_output", {24'b0, rx_output}, {24'b0, e.data});
            end
        end
        prev_pulse = valid || frame_error;
    end

    // Expected outcome of one frame from the framing rule alone.
    task automatic expect_frame(input logic [7:0] d, input logic stop);
        ev_t e;
        e.is_fe = !stop;
        if (stop) model_out = d;
        e.data = model_out;
        exp_q.push_back(e);
    endtask

    // Drive one frame; the line stays low for extra_low bit times after a low stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns, input int extra_low);
        rx_wire = 1'b0;
        #(bit_ns);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_wire = d[i];
            #(bit_ns);
        end
        rx_wire = stop;
        #(bit_ns);
        if (!stop && extra_low > 0) begin
            #(bit_ns * extra_low);
        end else begin
            rx_wire = 1'b1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         baud;
        logic       exp_fe;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   ev0;
        logic saw_busy;

        vecs[0] = '{data: 8'h00, stop: 1'b1, baud: 1_000_000, exp_fe: 1'b0, exp_out: 8'h00};
        vecs[1] = '{data: 8'h81, stop: 1'b1, baud: 1_000_000, exp_fe: 1'b0, exp_out: 8'h81};
        vecs[2] = '{data: 8'hA5, stop: 1'b1, baud: 1_000_000, exp_fe: 1'b0, exp_out: 8'hA5};
        vecs[3] = '{data: 8'hBE, stop: 1'b1, baud: 1_000_000, exp_fe: 1'b0, exp_out: 8'hBE};
        vecs[4] = '{data: 8'h77, stop: 1'b0, baud: 1_000_000, exp_fe: 1'b1, exp_out: 8'hBE};
        vecs[5] = '{data: 8'hC3, stop: 1'b1, baud:   980_000, exp_fe: 1'b0, exp_out: 8'hC3};
        vecs[6] = '{data: 8'hC3, stop: 1'b1, baud: 1_020_000, exp_fe: 1'b0, exp_out: 8'hC3};

        rst_n   = 1'b0;
        enable  = 1'b0;
        rx_wire = 1'b1;
        #(CLK_NS * 3.3);
        check("reset_rx_output", {24'b0, rx_output}, 32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_frame_error", {31'b0, frame_error}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        wait_cycles(2);
        enable = 1'b1;

        // Idle line.
        wait_cycles(1000);
        check("idle_events", ev_count, 0);
        check("idle_rx_output", {24'b0, rx_output}, 32'h0);
        check("idle_busy", {31'b0, busy}, 32'h0);

        // Table of single frames.
        for (int i = 0; i < 7; i++) begin
            ev_t e;
            ev0     = ev_count;
            e.is_fe = vecs[i].exp_fe;
            e.data  = vecs[i].exp_out;
            exp_q.push_back(e);
            model_out = vecs[i].exp_out;
            send_frame(vecs[i].data, vecs[i].stop, 1.0e9 / vecs[i].baud, 0);
            #(BIT_NS * 2.0);
            @(negedge clk);
            check("vec_event_count", ev_count, ev0 + 1);
            check("vec_rx_output", {24'b0, rx_output}, {24'b0, vecs[i].exp_out});
            check("vec_busy_after", {31'b0, busy}, 32'h0);
        end

        // Disable mid-frame.
        ev0 = ev_count;
        fork
            send_frame(8'h99, 1'b1, BIT_NS, 0);
            begin
                #(BIT_NS * 3.5);
                enable = 1'b0;
                @(posedge clk);
                #1;
                check("disable_busy", {31'b0, busy}, 32'h0);
                check("disable_rx_output", {24'b0, rx_output}, 32'hC3);
            end
        join
        #(BIT_NS * 2.0);
        enable = 1'b1;
        wait_cycles(CPB * 2);
        check("disable_no_event", ev_count, ev0);
        check("disable_rx_output_kept", {24'b0, rx_output}, 32'hC3);

        // Glitch shorter than half a bit.
        ev0      = ev_count;
        saw_busy = 1'b0;
        @(negedge clk);
        rx_wire = 1'b0;
        #(CLK_NS * 5.0);
        rx_wire = 1'b1;
        for (int c = 0; c < 2 * CPB; c++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_saw_busy", {31'b0, saw_busy}, 32'h1);
        check("glitch_busy_after", {31'b0, busy}, 32'h0);
        check("glitch_no_event", ev_count, ev0);

        // Framing error with the line held low afterwards.
        ev0 = ev_count;
        expect_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, BIT_NS, 2);
        @(negedge clk);
        check("break_event_count", ev_count, ev0 + 1);
        check("break_busy_held", {31'b0, busy}, 32'h1);
        check("break_rx_output", {24'b0, rx_output}, 32'hC3);
        rx_wire = 1'b1;
        wait_cycles(5);
        check("break_released", {31'b0, busy}, 32'h0);
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1, BIT_NS, 0);
        #(BIT_NS * 2.0);
        @(negedge clk);
        check("after_break_rx_output", {24'b0, rx_output}, 32'h3C);

        // Reset during data bit 4 of 0xFF.
        ev0 = ev_count;
        fork
            send_frame(8'hFF, 1'b1, BIT_NS, 0);
            begin
                #(BIT_NS * 5.5);
                rst_n = 1'b0;
                #1;
                check("midrst_rx_output", {24'b0, rx_output}, 32'h0);
                check("midrst_valid", {31'b0, valid}, 32'h0);
                check("midrst_frame_error", {31'b0, frame_error}, 32'h0);
                check("midrst_busy", {31'b0, busy}, 32'h0);
                #(BIT_NS);
                rst_n = 1'b1;
            end
        join
        model_out = 8'h00;
        #(BIT_NS * 2.0);
        check("midrst_no_event", ev_count, ev0);
        expect_frame(8'h42, 1'b1);
        send_frame(8'h42, 1'b1, BIT_NS, 0);
        #(BIT_NS * 2.0);
        @(negedge clk);
        check("after_rst_rx_output", {24'b0, rx_output}, 32'h42);

        // Randomized frames: random data, stop bit, +/-2% rate and gaps, including back-to-back.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       stop;
            int         pm;
            int         gap;
            real        bns;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pm   = $urandom_range(980, 1020);
            bns  = BIT_NS * 1000.0 / pm;
            gap  = $urandom_range(0, 2);
            if (!stop && gap == 0) gap = 1;
            expect_frame(d, stop);
            send_frame(d, stop, bns, 0);
            if (gap > 0) #(bns * gap);
        end
        #(BIT_NS * 3.0);
        @(negedge clk);
        check("final_pending_events", exp_q.size(), 0);
        check("final_rx_output", {24'b0, rx_output}, {24'b0, model_out});
        check("final_busy", {31'b0, busy}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
